// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined floating-point adder/subtractor.
// Widths are parameters of the user module, so width-dependent records are
// declared there; this package holds everything that is width independent.
package fp_pkg;

   // Operand / result class carried through the pipe
   typedef enum logic [1:0] {
      NORM = 2'd0,
      ZERO = 2'd1,
      INF  = 2'd2,
      NAN  = 2'd3
   } fp_class_e;

   // Classify an operand from its reduced exponent/fraction properties
   function automatic fp_class_e fp_classify(input logic exp_ones,
                                             input logic exp_zero,
                                             input logic frac_zero);
      fp_class_e cls;
      if (exp_ones) begin
         cls = frac_zero ? INF : NAN;
      end else if (exp_zero && frac_zero) begin
         cls = ZERO;
      end else begin
         cls = NORM;
      end
      return cls;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter. An all-zero vector returns WIDTH.
module fp_lzc #(
   parameter int WIDTH = 27,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] vec_i,
   output logic [CNT_W-1:0] cnt_o
);

   // Scan LSB to MSB so the highest set bit writes the count last
   always_comb begin
      cnt_o = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (vec_i[i]) begin
            cnt_o = CNT_W'(WIDTH - 1 - i);
         end else begin
            cnt_o = cnt_o;
         end
      end
   end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 adder/subtractor with valid/ready on both sides.
// S1 unpack/swap/align, S2 add or subtract, S3 normalise/round/pack.
module fp_addsub_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   op_a,
   input  logic [EXP_W+MAN_W:0]   op_b,
   input  logic                   sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic                   flag_invalid,
   output logic                   flag_overflow,
   output logic                   flag_inexact,
   output logic                   flag_zero
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int SW = MAN_W + 4;            // hidden + fraction + guard/round/sticky
   localparam int LW = $clog2(SW + 1);
   localparam int CW = (LW > EXP_W) ? LW : EXP_W;
   localparam int XW = EXP_W + 1;            // exponent with room for carry/round-up
   localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
   localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
   localparam logic [XW-1:0]    XONE     = {{EXP_W{1'b0}}, 1'b1};
   localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   // S1 -> S2 record: larger operand in sig_a, aligned smaller one in sig_b
   typedef struct packed {
      logic             sign;
      logic             zsign;     // sign of an exact-zero sum
      logic             sub_eff;
      logic [EXP_W-1:0] exp;
      logic [SW-1:0]    sig_a;
      logic [SW-1:0]    sig_b;     // low three bits are guard/round/sticky
      fp_class_e        cls;
   } s1_rec_t;

   // S2 -> S3 record: raw sum with carry bit on top
   typedef struct packed {
      logic             sign;
      logic             zsign;
      logic [EXP_W-1:0] exp;
      logic [SW:0]      sum;
      fp_class_e        cls;
   } s2_rec_t;

   logic    s1_valid_q, s2_valid_q, s3_valid_q;
   logic    s1_load_s, s2_load_s, s3_load_s;
   s1_rec_t s1_q, s1_d;
   s2_rec_t s2_q, s2_d;

   // Stage acceptance chain: a stage loads when empty or when it drains this cycle
   always_comb begin
      s3_load_s = ~s3_valid_q | out_ready;
      s2_load_s = ~s2_valid_q | s3_load_s;
      s1_load_s = ~s1_valid_q | s2_load_s;
      in_ready  = s1_load_s;
   end

   // ---------------- S1: unpack, swap, align ----------------
   logic             a_sign_s, b_sign_s, x_sign_s, swap_s, y_sticky_s;
   logic [EXP_W-1:0] a_exp_s, b_exp_s, x_exp_s, y_exp_s, x_eexp_s, y_eexp_s, diff_s;
   logic [MAN_W-1:0] a_frac_s, b_frac_s, x_frac_s, y_frac_s;
   logic [SW-1:0]    y_ext_s, y_sh_s;
   fp_class_e        a_cls_s, b_cls_s;

   // Decode operands, put the larger magnitude first and align the smaller
   always_comb begin
      a_sign_s = op_a[W-1];
      a_exp_s  = op_a[W-2:MAN_W];
      a_frac_s = op_a[MAN_W-1:0];
      b_sign_s = op_b[W-1] ^ sub;
      b_exp_s  = op_b[W-2:MAN_W];
      b_frac_s = op_b[MAN_W-1:0];
      a_cls_s  = fp_classify(&a_exp_s, ~|a_exp_s, ~|a_frac_s);
      b_cls_s  = fp_classify(&b_exp_s, ~|b_exp_s, ~|b_frac_s);
      swap_s   = {b_exp_s, b_frac_s} > {a_exp_s, a_frac_s};
      if (swap_s) begin
         x_sign_s = b_sign_s;
         x_exp_s  = b_exp_s;
         x_frac_s = b_frac_s;
         y_exp_s  = a_exp_s;
         y_frac_s = a_frac_s;
      end else begin
         x_sign_s = a_sign_s;
         x_exp_s  = a_exp_s;
         x_frac_s = a_frac_s;
         y_exp_s  = b_exp_s;
         y_frac_s = b_frac_s;
      end
      // Subnormals share the exponent of the smallest normal
      x_eexp_s   = (~|x_exp_s) ? EXP_ONE : x_exp_s;
      y_eexp_s   = (~|y_exp_s) ? EXP_ONE : y_exp_s;
      diff_s     = x_eexp_s - y_eexp_s;
      y_ext_s    = {|y_exp_s, y_frac_s, 3'b000};
      y_sh_s     = y_ext_s >> diff_s;
      // Any bit that fell off the bottom shows up as a mismatch when shifted back
      y_sticky_s = (y_sh_s << diff_s) != y_ext_s;

      s1_d.sign    = x_sign_s;
      s1_d.zsign   = a_sign_s & b_sign_s;
      s1_d.sub_eff = a_sign_s ^ b_sign_s;
      s1_d.exp     = x_eexp_s;
      s1_d.sig_a   = {|x_exp_s, x_frac_s, 3'b000};
      s1_d.sig_b   = {y_sh_s[SW-1:1], y_sh_s[0] | y_sticky_s};
      if ((a_cls_s == NAN) || (b_cls_s == NAN) ||
          ((a_cls_s == INF) && (b_cls_s == INF) && s1_d.sub_eff)) begin
         s1_d.cls = NAN;
      end else if ((a_cls_s == INF) || (b_cls_s == INF)) begin
         s1_d.cls = INF;            // the infinity is always the swapped-in A
      end else if ((a_cls_s == ZERO) && (b_cls_s == ZERO)) begin
         s1_d.cls = ZERO;
      end else begin
         s1_d.cls = NORM;
      end
   end

   // S1 register with its valid bit
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_q       <= {$bits(s1_rec_t){1'b0}};
      end else begin
         if (s1_load_s) s1_valid_q <= in_valid;
         if (s1_load_s && in_valid) s1_q <= s1_d;
      end
   end

   // ---------------- S2: add or subtract ----------------
   // Magnitude add/subtract; A >= B so a subtraction never goes negative
   always_comb begin
      s2_d.sign  = s1_q.sign;
      s2_d.zsign = s1_q.zsign;
      s2_d.exp   = s1_q.exp;
      s2_d.cls   = s1_q.cls;
      if (s1_q.sub_eff) begin
         s2_d.sum = {1'b0, s1_q.sig_a} - {1'b0, s1_q.sig_b};
      end else begin
         s2_d.sum = {1'b0, s1_q.sig_a} + {1'b0, s1_q.sig_b};
      end
   end

   // S2 register with its valid bit
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_q       <= {$bits(s2_rec_t){1'b0}};
      end else begin
         if (s2_load_s) s2_valid_q <= s1_valid_q;
         if (s2_load_s && s1_valid_q) s2_q <= s2_d;
      end
   end

   // ---------------- S3: normalise, round, pack ----------------
   logic [LW-1:0]    lz_s;
   logic [CW-1:0]    lz_ext_s, cap_s, shamt_s;
   logic [SW-1:0]    norm_s;
   logic [XW-1:0]    exp_n_s, exp_r_s;
   logic [MAN_W+1:0] mant_s;
   logic [MAN_W-1:0] frac_s;
   logic             rnd_up_s, inexact_s, is_zero_s;
   logic [W-1:0]     res_d;
   logic [3:0]       flags_d;   // {invalid, overflow, inexact, zero}

   fp_lzc #(.WIDTH(SW), .CNT_W(LW)) u_lzc (
      .vec_i (s2_q.sum[SW-1:0]),
      .cnt_o (lz_s)
   );

   // Normalise the sum, round to nearest even, then resolve specials
   always_comb begin
      lz_ext_s = CW'(lz_s);
      cap_s    = CW'(s2_q.exp - EXP_ONE);     // largest shift keeping exponent >= 1
      shamt_s  = (lz_ext_s > cap_s) ? cap_s : lz_ext_s;
      if (s2_q.sum[SW]) begin
         norm_s  = {s2_q.sum[SW:2], s2_q.sum[1] | s2_q.sum[0]};
         exp_n_s = {1'b0, s2_q.exp} + XONE;
      end else begin
         norm_s  = s2_q.sum[SW-1:0] << shamt_s;
         // A capped shift leaves the hidden bit clear: that is a subnormal
         exp_n_s = norm_s[SW-1] ? ({1'b0, s2_q.exp} - XW'(shamt_s)) : {XW{1'b0}};
      end
      rnd_up_s  = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
      inexact_s = |norm_s[2:0];
      mant_s    = {1'b0, norm_s[SW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up_s};
      if (mant_s[MAN_W+1]) begin
         exp_r_s = exp_n_s + XONE;
         frac_s  = mant_s[MAN_W:1];
      end else if ((exp_n_s == {XW{1'b0}}) && mant_s[MAN_W]) begin
         exp_r_s = XONE;                       // subnormal rounded up into the normal range
         frac_s  = mant_s[MAN_W-1:0];
      end else begin
         exp_r_s = exp_n_s;
         frac_s  = mant_s[MAN_W-1:0];
      end
      is_zero_s = (s2_q.cls == ZERO) || (~|s2_q.sum);

      case (s2_q.cls)
         NAN: begin
            res_d   = QNAN;
            flags_d = 4'b1000;
         end
         INF: begin
            res_d   = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
            flags_d = 4'b0000;
         end
         default: begin
            if (is_zero_s) begin
               res_d   = {s2_q.zsign, {(W-1){1'b0}}};
               flags_d = 4'b0001;
            end else if (exp_r_s >= {1'b0, EXP_ONES}) begin
               res_d   = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
               flags_d = 4'b0110;
            end else begin
               res_d   = {s2_q.sign, exp_r_s[EXP_W-1:0], frac_s};
               flags_d = {2'b00, inexact_s, 1'b0};
            end
         end
      endcase
   end

   // Output register: holds result and flags while the consumer stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         s3_valid_q    <= 1'b0;
         result        <= {W{1'b0}};
         flag_invalid  <= 1'b0;
         flag_overflow <= 1'b0;
         flag_inexact  <= 1'b0;
         flag_zero     <= 1'b0;
      end else begin
         if (s3_load_s) s3_valid_q <= s2_valid_q;
         if (s3_load_s && s2_valid_q) begin
            result        <= res_d;
            flag_invalid  <= flags_d[3];
            flag_overflow <= flags_d[2];
            flag_inexact  <= flags_d[1];
            flag_zero     <= flags_d[0];
         end
      end
   end

   assign out_valid = s3_valid_q;

endmodule
